range_xlate_fifo: RTL and testbench
===================================

// Module: range_xlate_fifo
// PURPOSE
// - Parametrised FIFO carrying words from a descending bus [HI:LO] to an ascending bus [LO:HI].
//   LO may be negative.
// - Per-word translation mode, INDEX or POSITION, captured with each write.
// - valid/ready handshake on both sides.
// - Generalises the plain cross-wired [2:-2]/[-2:2] model pair: adds depth, buffering and a
//   selectable bit mapping.
// - Reference netlist for Verilog-backend round-trip of reversed and negative ranges with
//   real state.
// PARAMETERS
// - HI      default 2      : MSB index of in_data, LSB-side index of out_data; HI >= LO
// - LO      default -2     : LSB index of in_data, first index of out_data; may be negative
// - DEPTH   default 4      : number of entries; power of 2, >= 2
// - W       derived        : HI - LO + 1 (localparam); AW = $clog2(DEPTH)
// PORTS
// - clk        in   1        : single clock, all state on rising edge
// - rst        in   1        : synchronous, active-high reset
// - in_valid   in   1        : write request
// - in_ready   out  1        : FIFO can accept (not full, not in reset)
// - in_data    in   [HI:LO]  : write word
// - in_mode    in   1        : 0 = INDEX, 1 = POSITION; sampled with the write, stored per entry
// - out_valid  out  1        : head entry present
// - out_ready  in   1        : read accept
// - out_data   out  [LO:HI]  : translated head word
// BEHAVIOUR
// - Clock and reset: one clock; reset is synchronous and active-high.
// - Reset values:
//   - wr_ptr = rd_ptr = 0 (AW+1 bits each, wrap bit included).
//   - in_ready = 0 while rst = 1, and 1 on the first cycle after rst falls.
//   - out_valid = 0; out_data = 0. Storage contents are not reset.
// - Push when in_valid & in_ready. Pop when out_valid & out_ready.
// - Flags:
//   - full  = (wr_ptr[AW] != rd_ptr[AW]) & (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
//   - empty = (wr_ptr == rd_ptr)
//   - in_ready = !full & !rst; out_valid = !empty.
// - Latency: a word pushed in cycle N gives out_valid = 1 in cycle N+1. There is no
//   combinational in->out passthrough.
// - Show-ahead: out_data is decoded from mem[rd_ptr] and its stored mode. It is forced to 0
//   when out_valid = 0.
// - INDEX mode (0): out_data[k] = in_data[k] for every k in LO..HI. The bit order as written
//   reverses.
// - POSITION mode (1): out_data[LO+j] = in_data[HI-j] for j = 0..W-1. The left-to-right
//   literal is preserved.
// - Simultaneous push and pop:
//   - Both pointers advance; occupancy is unchanged.
//   - When full, in_ready = 0, so only the pop occurs.
//   - When empty, out_valid = 0, so only the push occurs.
// - Wrap: pointers increment modulo 2*DEPTH; the MSB toggles on each wrap.
// - Reset mid-operation: all stored entries are discarded.
//   - out_valid drops on the cycle after rst is sampled high.
//   - No push or pop is accepted in any cycle where rst = 1.
// - Handshake rules: out_data and out_valid stay stable while out_valid & !out_ready.
//   The producer may deassert in_valid at any time.
// CONFIGURATION
// - Macro RANGE_XLATE_LEVEL_EN:
//   - Defined: adds output port level [AW:0], the registered occupancy = wr_ptr - rd_ptr.
//     It is 0 after reset and reaches DEPTH when full.
//   - Undefined: no level port, no extra logic; ports and behaviour are otherwise identical.
// TESTING (HI=2, LO=-2, DEPTH=4)
// - Reset: hold rst for 2 cycles with in_valid = 1.
//   -> in_ready = 0, out_valid = 0, out_data = 5'b00000; nothing is stored.
// - INDEX: push in_data = 5'b10110 with in_mode = 0.
//   -> next cycle out_valid = 1, out_data = 5'b01101 ([-2] = 0, [2] = 1).
// - POSITION: push 5'b10110 with in_mode = 1 -> out_data = 5'b10110.
//   Mixed modes in queue order are each decoded with their own stored mode.
// - Full/back-pressure: out_ready = 0; push 4 words.
//   -> in_ready = 0 after the 4th; a 5th in_valid is ignored; level = 4 (macro on).
//   Then pop all 4 in order -> empty, out_valid = 0.
// - Simultaneous and wrap: stream 10 words with in_valid = out_ready = 1 continuously.
//   -> one word per cycle, in order, occupancy constant at 1, pointers wrap cleanly.
// - Reset mid-operation: assert rst with 3 words queued.
//   -> next cycle out_valid = 0, level = 0; pushes resume after rst falls.

Source files
------------

// File: rtl/range_xlate_fifo.sv
// rtl/range_xlate_fifo.sv - FIFO from a descending [HI:LO] bus to an ascending [LO:HI] bus with per-word INDEX/POSITION mapping
// Optional macro RANGE_XLATE_LEVEL_EN adds the registered occupancy output 'level'.
module range_xlate_fifo #(
    parameter int HI    = 2,
    parameter int LO    = -2,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [HI:LO] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [LO:HI] out_data
`ifdef RANGE_XLATE_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int W  = HI - LO + 1;
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic [HI:LO]     mem_q [DEPTH];
    logic [DEPTH-1:0] mode_q;

    logic full;
    logic empty;
    logic push;
    logic pop;

    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty     = (wr_q == rd_q);
    assign in_ready  = !full && !rst;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !rst;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (push) begin
            wr_d = wr_q + {{AW{1'b0}}, 1'b1};
        end
        if (pop) begin
            rd_d = rd_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]]  <= in_data;
            mode_q[wr_q[AW-1:0]] <= in_mode;
        end
    end

`ifdef RANGE_XLATE_LEVEL_EN
    logic [AW:0] level_q;
    logic [AW:0] level_d;

    assign level_d = wr_d - rd_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign level = level_q;
`endif

    logic [HI:LO] head;
    logic         head_mode;
    logic [LO:HI] idx_word;
    logic [LO:HI] pos_word;

    assign head      = mem_q[rd_q[AW-1:0]];
    assign head_mode = mode_q[rd_q[AW-1:0]];

    // INDEX keeps each numbered bit; POSITION keeps the left-to-right order.
    for (genvar j = 0; j < W; j++) begin : g_map
        assign idx_word[LO+j] = head[LO+j];
        assign pos_word[LO+j] = head[HI-j];
    end

    always_comb begin
        out_data = '0;
        if (!empty) begin
            out_data = head_mode ? pos_word : idx_word;
        end
    end

endmodule

// File: tb/tb_range_xlate_fifo.sv
// tb/tb_range_xlate_fifo.sv - scoreboard bench for range_xlate_fifo (HI=2, LO=-2, DEPTH=4)
module tb_range_xlate_fifo;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:-2]  in_data;
    logic         in_mode;
    logic         out_valid;
    logic         out_ready;
    logic [-2:2]  out_data;
`ifdef RANGE_XLATE_LEVEL_EN
    logic [2:0]   level;
`endif

    int checks = 0;
    int errors = 0;

    logic [-2:2] exp_q [$];

    range_xlate_fifo #(.HI(2), .LO(-2), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef RANGE_XLATE_LEVEL_EN
        ,
        .level     (level)
`endif
    );

    always #5 clk = ~clk;

    // Hand-computed vectors: INDEX reverses the written literal, POSITION keeps it.
    logic [2:-2] vec_in   [10] = '{5'b10110, 5'b10110, 5'b11000, 5'b00001, 5'b11100,
                                   5'b01010, 5'b10011, 5'b01111, 5'b10000, 5'b00110};
    logic        vec_mode [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                   1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [-2:2] vec_exp  [10] = '{5'b01101, 5'b10110, 5'b00011, 5'b00001, 5'b00111,
                                   5'b01010, 5'b10011, 5'b11110, 5'b00001, 5'b00110};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %b expected no word", out_data);
            end else begin
                logic [-2:2] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %b expected %b", out_data, e);
                end
            end
        end
    end

    task automatic push(input int i);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = vec_in[i];
        in_mode  = vec_mode[i];
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(vec_exp[i]);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("push_accept", {31'b0, done}, 32'd1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_done", exp_q.size(), 0);
        @(negedge clk);
        chk("empty_out_valid", {31'b0, out_valid}, 0);
        chk("empty_out_data", {27'b0, out_data}, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 5'b10110;
        in_mode   = 1'b0;
        out_ready = 1'b0;

        // Reset held 2 cycles with in_valid high.
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", {31'b0, in_ready}, 0);
            chk("rst_out_valid", {31'b0, out_valid}, 0);
            chk("rst_out_data", {27'b0, out_data}, 0);
        end
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);
        chk("post_rst_nothing_stored", {31'b0, out_valid}, 0);
`ifdef RANGE_XLATE_LEVEL_EN
        chk("post_rst_level", {29'b0, level}, 0);
`endif
        @(posedge clk);
        #1;

        // INDEX with one-cycle latency.
        push(0);
        @(negedge clk);
        chk("latency_out_valid", {31'b0, out_valid}, 1);
        @(posedge clk);
        #1;
        drain();

        // POSITION, then mixed modes queued together.
        push(1);
        push(2);
        push(3);
        drain();

        // Full and back-pressure.
        for (int i = 2; i < 6; i++) push(i);
        @(negedge clk);
        chk("full_in_ready", {31'b0, in_ready}, 0);
`ifdef RANGE_XLATE_LEVEL_EN
        chk("full_level", {29'b0, level}, 4);
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = vec_in[6];
        in_mode  = vec_mode[6];
        repeat (2) begin
            @(negedge clk);
            chk("full_ignore_5th", {31'b0, in_ready}, 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Continuous stream through pointer wrap.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = vec_in[i];
            in_mode  = vec_mode[i];
            @(negedge clk);
            chk("stream_in_ready", {31'b0, in_ready}, 1);
            exp_q.push_back(vec_exp[i]);
            if (i > 0) begin
                chk("stream_out_valid", {31'b0, out_valid}, 1);
`ifdef RANGE_XLATE_LEVEL_EN
                chk("stream_level", {29'b0, level}, 1);
`endif
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset with 3 words queued; pushes during reset must be dropped.
        push(4);
        push(5);
        push(6);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = vec_in[7];
        in_mode  = vec_mode[7];
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
`ifdef RANGE_XLATE_LEVEL_EN
        chk("midrst_level", {29'b0, level}, 0);
`endif
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_nothing_stored", {31'b0, out_valid}, 0);
        @(posedge clk);
        #1;
        push(9);
        drain();

        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
